// File: rtl/max_pool_stream_pkg.sv
// Shared defaults and helpers for the streaming 2x2 / stride-2 max-pool stage.
package max_pool_stream_pkg;

    localparam int unsigned DEF_FILTERS  = 1;
    localparam int unsigned DEF_IN_SIZE  = 4;
    localparam int unsigned DEF_BIT_SIZE = 16;

    // Pooled map side length: floor pooling drops an odd trailing row/column.
    function automatic int unsigned pool_out_size(input int unsigned in_size);
        return in_size / 2;
    endfunction

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max_pool_stream_pool_max_unit.sv
// pool_max_unit: combinational per-channel signed max of two packed channel buses.
//   a, b : FILTERS*BIT_SIZE operands, channel k at [k*BIT_SIZE +: BIT_SIZE]
//   y    : per-channel max, same packing
module pool_max_unit
    import max_pool_stream_pkg::*;
#(
    parameter int unsigned FILTERS  = DEF_FILTERS,
    parameter int unsigned BIT_SIZE = DEF_BIT_SIZE
) (
    input  logic [FILTERS*BIT_SIZE-1:0] a,
    input  logic [FILTERS*BIT_SIZE-1:0] b,
    output logic [FILTERS*BIT_SIZE-1:0] y
);

    for (genvar k = 0; k < FILTERS; k++) begin : g_ch
        logic signed [BIT_SIZE-1:0] ak;
        logic signed [BIT_SIZE-1:0] bk;
        assign ak = a[k*BIT_SIZE +: BIT_SIZE];
        assign bk = b[k*BIT_SIZE +: BIT_SIZE];
        assign y[k*BIT_SIZE +: BIT_SIZE] = (ak >= bk) ? ak : bk;
    end

endmodule

// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming 2x2 / stride-2 max pool over a raster-ordered feature map.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake, one spatial position (all channels) per beat
//   in_data             : FILTERS*BIT_SIZE pixel, channel k at [k*BIT_SIZE +: BIT_SIZE]
//   out_valid/out_ready : output handshake, one pooled position per 2x2 window
//   out_data            : pooled result, same channel packing
//   frame_done          : 1-cycle pulse after the frame's last pooled beat is accepted
module max_pool_stream
    import max_pool_stream_pkg::*;
#(
    parameter int unsigned FILTERS  = DEF_FILTERS,
    parameter int unsigned IN_SIZE  = DEF_IN_SIZE,
    parameter int unsigned BIT_SIZE = DEF_BIT_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FILTERS*BIT_SIZE-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [FILTERS*BIT_SIZE-1:0] out_data,
    output logic                        frame_done
);

    localparam int unsigned OUT_SIZE = pool_out_size(IN_SIZE);
    localparam int unsigned W        = FILTERS * BIT_SIZE;
    localparam int unsigned CW       = idx_width(IN_SIZE);
    localparam int unsigned LW       = idx_width(OUT_SIZE);
    localparam int unsigned LAST     = 2 * OUT_SIZE - 1;

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [W-1:0]  hold;
    logic [W-1:0]  linebuf [OUT_SIZE];
    logic [W-1:0]  lb_rd;
    logic [W-1:0]  h_max;
    logic [W-1:0]  v_max;
    logic [LW-1:0] lb_idx;
    logic          last_q;
    logic          accept;
    logic          col_end;
    logic          row_end;
    logic          load;
    logic          win_last;
    logic          drain;

    // Single-entry output register: accept whenever it is empty or being drained.
    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    assign col_end  = (col == CW'(IN_SIZE - 1));
    assign row_end  = (row == CW'(IN_SIZE - 1));
    assign lb_idx   = LW'(col >> 1);
    assign lb_rd    = linebuf[lb_idx];
    assign load     = accept & col[0] & row[0];
    assign win_last = (row == CW'(LAST)) & (col == CW'(LAST));

    // Horizontal pair max, then combine with the partial max from the row above.
    pool_max_unit #(.FILTERS(FILTERS), .BIT_SIZE(BIT_SIZE)) u_hmax (
        .a (hold),
        .b (in_data),
        .y (h_max)
    );

    pool_max_unit #(.FILTERS(FILTERS), .BIT_SIZE(BIT_SIZE)) u_vmax (
        .a (lb_rd),
        .b (h_max),
        .y (v_max)
    );

    // Raster position of the next accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Partial-max storage; contents are always rewritten before being read.
    always_ff @(posedge clk) begin
        if (accept && !col[0]) begin
            hold <= in_data;
        end
        if (accept && col[0] && !row[0]) begin
            linebuf[lb_idx] <= h_max;
        end
    end

    // Output register; a new load wins over a same-edge drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            last_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= drain & last_q;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= v_max;
                last_q    <= win_last;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
